// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the pipelined bitwise logic unit:
//   - 3-bit operation codes OP_AND .. OP_PASS
//   - is_acc_op : true for the three accumulating operations
//   - lu_bit    : one-bit result of an operation given a, b and acc bits.
// All operations are bitwise, so a WIDTH-bit result is lu_bit applied to
// every bit position. This keeps the helper independent of WIDTH.
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_NOR     = 3'b011;
  localparam logic [2:0] OP_ACC_OR  = 3'b100;
  localparam logic [2:0] OP_ACC_AND = 3'b101;
  localparam logic [2:0] OP_ACC_XOR = 3'b110;
  localparam logic [2:0] OP_PASS    = 3'b111;

  // Accumulating ops write their result into acc as well as out.
  function automatic logic is_acc_op(input logic [2:0] op);
    logic r;
    case (op)
      OP_ACC_OR,
      OP_ACC_AND,
      OP_ACC_XOR: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  // Single-bit result; b is ignored by accumulate and pass ops.
  function automatic logic lu_bit(input logic [2:0] op, input logic a,
                                  input logic b, input logic acc);
    logic r;
    case (op)
      OP_AND:     r = a & b;
      OP_OR:      r = a | b;
      OP_XOR:     r = a ^ b;
      OP_NOR:     r = ~(a | b);
      OP_ACC_OR:  r = acc | a;
      OP_ACC_AND: r = acc & a;
      OP_ACC_XOR: r = acc ^ a;
      OP_PASS:    r = a;
      default:    r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// ---------------------------------------------------------------------------
// logic_unit_core
// Purely combinational op decode and result function.
// Ports:
//   op      in  3      operation code
//   a, b    in  WIDTH  operands
//   acc     in  WIDTH  current accumulator value
//   acc_clr in  1      clear request; with an accumulate op the result is a
//   result  out WIDTH  operation result
//   acc_op  out 1      op is an accumulating op
// ---------------------------------------------------------------------------
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] result,
  output logic             acc_op
);

  // Result decode; clear-then-load makes every accumulate op yield a.
  always_comb begin
    acc_op = is_acc_op(op);
    result = {WIDTH{1'b0}};
    if (acc_op && acc_clr) begin
      result = a;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        result[i] = lu_bit(op, a[i], b[i], acc[i]);
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Registered bitwise logic unit with valid/ready handshake and an internal
// accumulator for the ACC_* operations.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  input beat handshake (in_ready = !out_valid || out_ready)
//   a, b, op        operands and op code, sampled on accept
//   acc_clr         synchronous accumulator clear (honoured even when stalled)
//   out_valid/ready output handshake
//   out, zero, ones registered result and its all-zero / all-one flags
// ---------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones
);

  logic [WIDTH-1:0] result_s;
  logic             acc_op_s;
  logic             accept_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] out_r;
  logic             out_valid_r;
  logic             zero_r;
  logic             ones_r;

  // Slot frees when empty or being drained this cycle.
  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op      (op),
    .a       (a),
    .b       (b),
    .acc     (acc_r),
    .acc_clr (acc_clr),
    .result  (result_s),
    .acc_op  (acc_op_s)
  );

  // Output register: load on accept, drop valid on drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      ones_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_r       <= result_s;
      zero_r      <= (result_s == {WIDTH{1'b0}});
      ones_r      <= &result_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Accumulator: accepted accumulate op wins over a plain clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (accept_s && acc_op_s) begin
      acc_r <= result_s;
    end else if (acc_clr) begin
      acc_r <= {WIDTH{1'b0}};
    end else begin
      acc_r <= acc_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign zero      = zero_r;
  assign ones      = ones_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
// Directed bench for logic_unit_pipe at WIDTH = 32, 1 and 64.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

  localparam logic [2:0] AND_  = 3'b000;
  localparam logic [2:0] OR_   = 3'b001;
  localparam logic [2:0] XOR_  = 3'b010;
  localparam logic [2:0] NOR_  = 3'b011;
  localparam logic [2:0] AOR   = 3'b100;
  localparam logic [2:0] AAND  = 3'b101;
  localparam logic [2:0] AXOR  = 3'b110;
  localparam logic [2:0] PASS_ = 3'b111;

  logic clk;
  logic rst_n;

  // WIDTH = 32 instance
  logic        v32, rdy32, clr32, ov32, ordy32, z32, o32;
  logic [31:0] a32, b32, out32;
  logic [2:0]  op32;
  // WIDTH = 1 instance
  logic        v1, rdy1, clr1, ov1, ordy1, z1, o1;
  logic [0:0]  a1, b1, out1;
  logic [2:0]  op1;
  // WIDTH = 64 instance
  logic        v64, rdy64, clr64, ov64, ordy64, z64, o64;
  logic [63:0] a64, b64, out64;
  logic [2:0]  op64;

  int compared = 0;
  int mismatched = 0;

  logic_unit_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32),
    .op(op32), .acc_clr(clr32), .out_valid(ov32), .out_ready(ordy32), .out(out32),
    .zero(z32), .ones(o32));

  logic_unit_pipe #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1),
    .op(op1), .acc_clr(clr1), .out_valid(ov1), .out_ready(ordy1), .out(out1),
    .zero(z1), .ones(o1));

  logic_unit_pipe #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .a(a64), .b(b64),
    .op(op64), .acc_clr(clr64), .out_valid(ov64), .out_ready(ordy64), .out(out64),
    .zero(z64), .ones(o64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat32(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic c);
    v32 = 1'b1; op32 = o; a32 = aa; b32 = bb; clr32 = c;
    @(posedge clk); #1;
    v32 = 1'b0; clr32 = 1'b0;
  endtask

  task automatic beat1(input logic [2:0] o, input logic aa, input logic bb, input logic c);
    v1 = 1'b1; op1 = o; a1 = aa; b1 = bb; clr1 = c;
    @(posedge clk); #1;
    v1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic beat64(input logic [2:0] o, input logic [63:0] aa, input logic [63:0] bb,
                        input logic c);
    v64 = 1'b1; op64 = o; a64 = aa; b64 = bb; clr64 = c;
    @(posedge clk); #1;
    v64 = 1'b0; clr64 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    v32 = 1'b0; a32 = 32'h0; b32 = 32'h0; op32 = 3'b000; clr32 = 1'b0; ordy32 = 1'b1;
    v1  = 1'b0; a1  = 1'b0;  b1  = 1'b0;  op1  = 3'b000; clr1  = 1'b0; ordy1  = 1'b1;
    v64 = 1'b0; a64 = 64'h0; b64 = 64'h0; op64 = 3'b000; clr64 = 1'b0; ordy64 = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", {63'd0, ov32}, 64'd0);
    check("rst_out",       {32'd0, out32}, 64'd0);
    check("rst_zero",      {63'd0, z32}, 64'd0);
    check("rst_ones",      {63'd0, o32}, 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_idle", {63'd0, rdy32}, 64'd1);

    // Basic OR
    beat32(OR_, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0);
    check("or1_valid", {63'd0, ov32}, 64'd1);
    check("or1_out",   {32'd0, out32}, 64'h00000000FFFFFFFF);
    check("or1_ones",  {63'd0, o32}, 64'd1);
    beat32(OR_, 32'h0000FFFF, 32'hFFFF0000, 1'b0);
    check("or2_out",   {32'd0, out32}, 64'h00000000FFFFFFFF);
    beat32(OR_, 32'h00000003, 32'h00000002, 1'b0);
    check("or3_out",   {32'd0, out32}, 64'h0000000000000003);
    check("or3_ones",  {63'd0, o32}, 64'd0);
    check("or3_zero",  {63'd0, z32}, 64'd0);
    @(posedge clk); #1;
    check("drain_valid", {63'd0, ov32}, 64'd0);
    check("drain_out_hold", {32'd0, out32}, 64'h0000000000000003);

    // Op sweep
    beat32(AND_, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    check("and_out",  {32'd0, out32}, 64'h00000000F000F000);
    beat32(XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    check("xor_out",  {32'd0, out32}, 64'h000000000FF00FF0);
    beat32(NOR_, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    check("nor_out",  {32'd0, out32}, 64'h00000000000F000F);
    beat32(PASS_, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    check("pass_out", {32'd0, out32}, 64'h00000000F0F0F0F0);
    beat32(AND_, 32'hF0F0F0F0, 32'h00000000, 1'b0);
    check("and0_out",  {32'd0, out32}, 64'd0);
    check("and0_zero", {63'd0, z32}, 64'd1);

    // Accumulate sequence
    beat32(AOR, 32'h00000001, 32'hDEADBEEF, 1'b1);
    check("acc1_out", {32'd0, out32}, 64'h0000000000000001);
    beat32(AOR, 32'h00000100, 32'h00000000, 1'b0);
    check("acc2_out", {32'd0, out32}, 64'h0000000000000101);
    beat32(AXOR, 32'h00000001, 32'h00000000, 1'b0);
    check("acc3_out", {32'd0, out32}, 64'h0000000000000100);
    clr32 = 1'b1;
    @(posedge clk); #1;
    clr32 = 1'b0;
    check("clr_only_out_hold", {32'd0, out32}, 64'h0000000000000100);
    beat32(AAND, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    check("acc_and_after_clr", {32'd0, out32}, 64'd0);
    check("acc_and_zero", {63'd0, z32}, 64'd1);
    beat32(AAND, 32'h00005A5A, 32'h00000000, 1'b1);
    check("clr_load_and", {32'd0, out32}, 64'h0000000000005A5A);
    beat32(PASS_, 32'h0F0F0000, 32'h00000000, 1'b1);
    check("pass_with_clr", {32'd0, out32}, 64'h000000000F0F0000);
    beat32(AOR, 32'h0000000F, 32'h00000000, 1'b0);
    check("acc_after_pass_clr", {32'd0, out32}, 64'h000000000000000F);
    beat32(AOR, 32'h00005A50, 32'h00000000, 1'b0);
    check("acc_rebuild", {32'd0, out32}, 64'h0000000000005A5F);

    // Backpressure
    beat32(XOR_, 32'h00000001, 32'h00000003, 1'b0);
    check("bp_setup_out", {32'd0, out32}, 64'h0000000000000002);
    ordy32 = 1'b0;
    v32 = 1'b1; op32 = AOR; a32 = 32'h00000100; b32 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #0;
      check("bp_in_ready", {63'd0, rdy32}, 64'd0);
      @(posedge clk); #1;
      check("bp_out_stable", {32'd0, out32}, 64'h0000000000000002);
      check("bp_valid_held", {63'd0, ov32}, 64'd1);
    end
    ordy32 = 1'b1;
    #0;
    check("bp_release_ready", {63'd0, rdy32}, 64'd1);
    @(posedge clk); #1;
    check("bp_pending_out", {32'd0, out32}, 64'h0000000000005B5F);
    a32 = 32'h00020000;
    @(posedge clk); #1;
    check("bp_next_out", {32'd0, out32}, 64'h0000000000025B5F);
    check("bp_next_valid", {63'd0, ov32}, 64'd1);
    v32 = 1'b0;
    @(posedge clk); #1;
    check("bp_drained", {63'd0, ov32}, 64'd0);

    // Reset mid-stream
    beat32(AOR, 32'h0000ABCD, 32'h00000000, 1'b1);
    check("mid_pre_out", {32'd0, out32}, 64'h000000000000ABCD);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, ov32}, 64'd0);
    check("mid_rst_out",   {32'd0, out32}, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    beat32(AOR, 32'h00000001, 32'h00000000, 1'b0);
    check("post_rst_acc", {32'd0, out32}, 64'h0000000000000001);

    // WIDTH = 1
    beat1(NOR_, 1'b0, 1'b0, 1'b0);
    check("w1_nor_out",  {63'd0, out1}, 64'd1);
    check("w1_nor_ones", {63'd0, o1}, 64'd1);
    check("w1_nor_zero", {63'd0, z1}, 64'd0);
    beat1(OR_, 1'b1, 1'b0, 1'b0);
    check("w1_or_out", {63'd0, out1}, 64'd1);
    beat1(AND_, 1'b1, 1'b0, 1'b0);
    check("w1_and_zero", {63'd0, z1}, 64'd1);
    beat1(AXOR, 1'b1, 1'b0, 1'b1);
    check("w1_acc1", {63'd0, out1}, 64'd1);
    beat1(AXOR, 1'b1, 1'b0, 1'b0);
    check("w1_acc2", {63'd0, out1}, 64'd0);
    check("w1_ready", {63'd0, rdy1}, 64'd1);

    // WIDTH = 64
    beat64(OR_, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 1'b0);
    check("w64_or_out",  out64, 64'hFFFFFFFFFFFFFFFF);
    check("w64_or_ones", {63'd0, o64}, 64'd1);
    beat64(AOR, 64'h8000000000000000, 64'h0, 1'b1);
    check("w64_acc1", out64, 64'h8000000000000000);
    beat64(AOR, 64'h0000000000000001, 64'h0, 1'b0);
    check("w64_acc2", out64, 64'h8000000000000001);
    check("w64_valid", {63'd0, ov64}, 64'd1);
    check("w64_ready", {63'd0, rdy64}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
